// File: rtl/systolic_pkg.sv
// systolic_pkg: shared opcodes, instruction field positions and sequencer state encoding
package systolic_pkg;
    localparam int INSTR_W = 64;
    localparam logic [4:0] OP_NONE      = 5'h00;
    localparam logic [4:0] OP_MAC       = 5'h01;
    localparam logic [4:0] OP_SEND_WT   = 5'h02;
    localparam logic [4:0] OP_STORE_OUT = 5'h03;
    localparam logic [4:0] OP_RX_INP    = 5'h04;
    localparam logic [4:0] OP_RX_WT     = 5'h05;
    localparam logic [4:0] OP_TX_OUT    = 5'h06;
    localparam logic [4:0] OP_RST_ACC   = 5'h07;
    localparam logic [4:0] OP_NOP       = 5'h1F;
    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 4;
    localparam int ADDR_LSB = 5;
    localparam int ADDR_MSB = 20;
    localparam int DATA_LSB = 21;
    localparam int DATA_MSB = 52;
    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_STORE, ST_WAIT_TX} seq_state_e;
    function automatic logic op_is_work(input logic [4:0] op);
        return op >= OP_MAC && op <= OP_RST_ACC;
    endfunction
    function automatic logic op_is_illegal(input logic [4:0] op);
        return op > OP_RST_ACC && op < OP_NOP;
    endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with push/pop/flush and occupancy count
//   clk, rst_n (async active-low)
//   push_i/wdata_i : write side, ignored when full or flushing
//   pop_i/rdata_o  : read side, rdata_o shows the head entry combinationally
//   flush_i        : empties the FIFO on the next edge, dropping any push
//   count_o, full_o, empty_o : occupancy status
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers host instructions and issues legal ones to the decoder, stalling while the array streams or a transmit is pending
//   clk, rst_n (async active-low)
//   in_valid/in_ready/in_instr : host push port (in_ready = FIFO not full)
//   flush                      : clears FIFO, wait state and issue register
//   issue_instr/issue_valid    : registered decoder output, zero when idle
//   tx_done                    : transmit-finished pulse releasing WAIT_TX
//   busy, illegal_op (sticky), fifo_count : status
//   Optional INSTR_SEQ_PERF_EN adds saturating perf_issued/perf_stall counters.
module instr_sequencer
    import systolic_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int STREAM_CYCLES = 16,
    parameter int STORE_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic                   flush,
    output logic [INSTR_W-1:0]     issue_instr,
    output logic                   issue_valid,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   illegal_op,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef INSTR_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_stall
`endif
);
    localparam int CW = $clog2((STREAM_CYCLES > STORE_CYCLES ? STREAM_CYCLES : STORE_CYCLES) + 1);

    seq_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [INSTR_W-1:0] issue_instr_q, issue_instr_d, head;
    logic               issue_valid_q, issue_valid_d;
    logic               illegal_q, illegal_d;
    logic               fifo_full, fifo_empty, pop;
    logic [4:0]         op;

    instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (in_valid),
        .pop_i  (pop),
        .flush_i(flush),
        .wdata_i(in_instr),
        .rdata_o(head),
        .count_o(fifo_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign op          = head[OPC_MSB:OPC_LSB];
    assign pop         = state_q == ST_IDLE && !fifo_empty && !flush;
    assign busy        = !fifo_empty || state_q != ST_IDLE;
    assign issue_instr = issue_instr_q;
    assign issue_valid = issue_valid_q;
    assign illegal_op  = illegal_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        issue_valid_d = pop && op_is_work(op);
        issue_instr_d = issue_valid_d ? head : '0;
        illegal_d     = illegal_q | (pop && op_is_illegal(op));
        case (state_q)
            ST_IDLE: begin
                if (pop && (op == OP_MAC || op == OP_SEND_WT)) begin
                    state_d = ST_STREAM;
                    cnt_d   = CW'(STREAM_CYCLES - 1);
                end else if (pop && op == OP_STORE_OUT) begin
                    state_d = ST_STORE;
                    cnt_d   = CW'(STORE_CYCLES - 1);
                end else if (pop && op == OP_TX_OUT) begin
                    state_d = ST_WAIT_TX;
                end
            end
            // Leaving at count 1 makes the first IDLE cycle pop, so the next
            // issue lands exactly STREAM/STORE_CYCLES after the blocking one.
            ST_STREAM, ST_STORE: begin
                state_d = cnt_q <= CW'(1) ? ST_IDLE : state_q;
                cnt_d   = cnt_q <= CW'(1) ? '0 : cnt_q - CW'(1);
            end
            // A tx_done coincident with the TX issue belongs to an earlier transfer
            ST_WAIT_TX: state_d = tx_done && !issue_valid_q ? ST_IDLE : ST_WAIT_TX;
        endcase
        if (flush) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            issue_valid_d = 1'b0;
            issue_instr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            issue_instr_q <= '0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            issue_instr_q <= issue_instr_d;
            issue_valid_q <= issue_valid_d;
            illegal_q     <= illegal_d;
        end
    end

`ifdef INSTR_SEQ_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;
    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (issue_valid_q && perf_issued_q != '1) perf_issued_q <= perf_issued_q + 32'd1;
            if (!fifo_empty && state_q != ST_IDLE && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end
`endif
endmodule
